// File: rtl/led_matrix_scan_if.sv
// Producer-side bundle for the LED matrix scan driver: frame/brightness load path and the
// row/column drive outputs.
interface led_matrix_scan_if #(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned COLS     = 4,
   parameter int unsigned PWM_BITS = 3
);
   logic                   enable;
   logic [COLS*ROWS-1:0]   frame_in;
   logic [PWM_BITS-1:0]    bright_in;
   logic                   load;
   logic                   pending;
   logic                   frame_sync;
   logic [ROWS-1:0]        row_n;
   logic [COLS-1:0]        col_n;

   modport master (
      output enable, frame_in, bright_in, load,
      input  pending, frame_sync, row_n, col_n
   );

   modport slave (
      input  enable, frame_in, bright_in, load,
      output pending, frame_sync, row_n, col_n
   );
endinterface

// File: rtl/led_matrix_scan.sv
// Multiplexed LED-matrix scan driver with global PWM brightness and a double-buffered frame
// that is only swapped in at a frame boundary.
module led_matrix_scan #(
   parameter int unsigned ROWS     = 8,
   parameter int unsigned COLS     = 4,
   parameter int unsigned DIV      = 375,
   parameter int unsigned PWM_BITS = 3
) (
   input logic               clk,
   input logic               resetn,
   led_matrix_scan_if.slave  bus
);
   localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned COL_W = $clog2(COLS);
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
   localparam logic [COL_W-1:0] COL_MAX = COL_W'(COLS - 1);

   logic [PRE_W-1:0]      r_pre;
   logic [PWM_BITS-1:0]   r_pwm;
   logic [COL_W-1:0]      r_col;
   logic [COLS*ROWS-1:0]  r_shadow;
   logic [PWM_BITS-1:0]   r_shadow_bright;
   logic [COLS*ROWS-1:0]  r_disp;
   logic [PWM_BITS-1:0]   r_disp_bright;
   logic                  r_pending;
   logic                  r_frame_sync;
   logic [ROWS-1:0]       r_row_n;
   logic [COLS-1:0]       r_col_n;

   logic                  w_step;
   logic                  w_pwm_max;
   logic                  w_boundary;
   logic                  w_col_act;
   logic [ROWS-1:0]       w_col_bits;
   logic [ROWS-1:0]       w_row_n_d;
   logic [COLS-1:0]       w_col_n_d;

   assign w_step     = (r_pre == PRE_MAX);
   assign w_pwm_max  = &r_pwm;
   assign w_boundary = w_step && w_pwm_max && (r_col == COL_MAX);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_pre <= '0;
         r_pwm <= '0;
         r_col <= '0;
      end else begin
         r_pre <= w_step ? '0 : r_pre + 1'b1;
         if (w_step) begin
            r_pwm <= r_pwm + 1'b1;
            if (w_pwm_max) begin
               r_col <= (r_col == COL_MAX) ? '0 : r_col + 1'b1;
            end
         end
      end
   end

   // The old shadow moves to display before a same-cycle load overwrites it.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_shadow        <= '0;
         r_shadow_bright <= '0;
         r_disp          <= '0;
         r_disp_bright   <= '0;
         r_pending       <= 1'b0;
         r_frame_sync    <= 1'b0;
      end else begin
         r_frame_sync <= w_boundary && r_pending;
         if (w_boundary && r_pending) begin
            r_disp        <= r_shadow;
            r_disp_bright <= r_shadow_bright;
         end
         if (bus.load) begin
            r_shadow        <= bus.frame_in;
            r_shadow_bright <= bus.bright_in;
            r_pending       <= 1'b1;
         end else if (w_boundary) begin
            r_pending <= 1'b0;
         end
      end
   end

   // Last PWM step of each column is dead time to avoid ghosting.
   assign w_col_act  = bus.enable && !w_pwm_max;
   assign w_col_bits = r_disp[r_col*ROWS +: ROWS];

   always_comb begin
      w_col_n_d = '1;
      w_row_n_d = '1;
      if (w_col_act) begin
         w_col_n_d[r_col] = 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            w_row_n_d[r] = !(w_col_bits[r] && (r_pwm < r_disp_bright));
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_row_n <= '1;
         r_col_n <= '1;
      end else begin
         r_row_n <= w_row_n_d;
         r_col_n <= w_col_n_d;
      end
   end

   assign bus.pending    = r_pending;
   assign bus.frame_sync = r_frame_sync;
   assign bus.row_n      = r_row_n;
   assign bus.col_n      = r_col_n;
endmodule

// File: doc/led_matrix_scan.md
# led_matrix_scan

Parametrised multiplexed LED-matrix scan driver: the generalised successor to the fixed 8x4 display driver. It scans COLS columns of ROWS LEDs with global PWM brightness. Frame data and brightness are double-buffered, so a new frame only becomes visible at a frame boundary (no tearing). A frame-sync pulse is provided for the producer, e.g. a CPU register-mirror or the status display in a board-level test top.

## Interface
- ROWS, 8: LEDs per column (row lines); 1..16.
- COLS, 4: number of columns scanned; 2..16.
- DIV, 375: clock cycles per PWM step; >=1.
- PWM_BITS, 3: brightness resolution; 1..6.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  high = display driven; low forces all row/col outputs inactive (counters keep running).
- frame_in  in  COLS*ROWS  pixel data; column c is bits [c*ROWS +: ROWS]; 1 = lit.
- bright_in  in  PWM_BITS  brightness; duty = bright/2^PWM_BITS; 0 = dark.
- load  in  1  single-cycle strobe; captures frame_in and bright_in into the shadow buffer.
- pending  out  1  shadow holds a frame not yet displayed.
- frame_sync  out  1  one-cycle pulse when the display buffer is (re)latched at the frame boundary.
- row_n  out  ROWS  row drives, active-low.
- col_n  out  COLS  column selects, active-low.

## Operation
- Counters:
  - pre counts 0..DIV-1.
  - step = (pre == DIV-1).
  - pwm counts 0..2^PWM_BITS-1 and advances on step.
  - col counts 0..COLS-1 and advances on step when pwm is at max.
  - col wraps to 0 (no gaps for non-power-of-2 COLS).
- Frame boundary: the cycle where step is true, pwm is at max and col == COLS-1.
- Column select: col_n[c] is active (0) iff enable, c == col, and pwm != 2^PWM_BITS-1. The last PWM step of every column is dead time (anti-ghosting).
- Rows: row_n[r] is active iff the column is active, disp[col][r] == 1, and pwm < disp_bright. Unsigned compare, PWM_BITS wide.
- Shadow buffer, on load:
  - shadow_frame <= frame_in, shadow_bright <= bright_in, pending <= 1.
  - A load while already pending overwrites the shadow (last wins).
- At the frame boundary with pending = 1:
  - disp <= shadow_frame, disp_bright <= shadow_bright.
  - frame_sync pulses.
  - pending <= 0, unless load is asserted in the same cycle.
- Simultaneous load and boundary:
  - The old shadow moves to display.
  - The new data goes to the shadow; pending stays 1.
  - If pending was 0, the new load is displayed at the next boundary.
- At the frame boundary with pending = 0: no transfer, frame_sync stays 0.
- Reset (any time, including mid-frame):
  - pre, pwm and col are 0.
  - disp, disp_bright, shadow and pending are 0.
  - frame_sync is 0.
  - row_n and col_n are all 1.
  - Scanning resumes from column 0 on the first edge after release.

## Timing
- All outputs are registered. row_n/col_n reflect the counter and buffer state of the previous cycle (1-cycle latency).
- pending rises on the edge after load.
- frame_sync rises on the edge that ends the boundary cycle, i.e. simultaneous with pwm/col returning to 0.
- The new display data appears on row_n one cycle after frame_sync.
- Column dwell = DIV*2^PWM_BITS cycles; active for DIV*(2^PWM_BITS-1) of them.
- Frame period = COLS*DIV*2^PWM_BITS cycles (defaults: 12 MHz gives 1 kHz frame).
- Lit time per column = DIV*bright cycles, starting at the column's first PWM step.
- enable acts on outputs with the same 1-cycle latency and has no effect on the counters or buffers.

## Test plan
Unless stated, DIV=2, PWM_BITS=2, COLS=4, ROWS=8: 2-cycle steps, 8-cycle dwell, 32-cycle frame.
- Reset:
  - Hold resetn=0 mid-scan -> row_n=8'hFF, col_n=4'hF, pending=0, frame_sync=0 immediately (async).
  - After release -> col_n=4'hE for 6 cycles, then 4'hF for 2 cycles, then 4'hD.
- Load/display:
  - Load frame_in=32'hA5_00_FF_01, bright=2 -> pending=1.
  - At the next boundary -> frame_sync pulses once, pending=0.
  - Column 0 -> row_n=8'hFE for 4 cycles then 8'hFF.
  - Column 1 -> row_n=8'h00 for 4 cycles.
- Brightness:
  - bright=0 -> row_n stays 8'hFF all frame.
  - bright=3 -> rows lit 6 of every 8 cycles, dark during the dead step.
- Double buffer:
  - Load A, then load B before the boundary -> B displayed, exactly one frame_sync.
  - Load C exactly in the boundary cycle with B pending -> B shown first; C shown after the next boundary; pending stays 1 in between.
- Enable:
  - Deassert enable mid-column -> row_n/col_n all 1 on the next cycle.
  - Reassert enable -> scan position unchanged relative to the free-running counters.
- Non-power-of-2 geometry: COLS=3, DIV=1 -> col_n cycles 6,5,3 (inactive dead step between each); frame period 3*2^PWM_BITS cycles.
